// File: rtl/pixel_rgb_formatter.sv
// pixel_rgb_formatter
//   Converts three IEEE-754 single-precision channel intensities (nominal
//   range [0,1)) into COLOR_W-bit integer channels. It is a three-stage
//   valid/ready pipeline: classify -> align -> quantise. The pixel
//   coordinate and visibility sideband travel in the same stage registers
//   as the pixel they belong to.
//
//   Optional feature macro: PIXEL_FMT_DITHER_EN
//     When defined, 2x2 ordered dithering is added before quantisation.
//     The dither value is taken from the pixel's own x[0]/y[0].
//     When undefined, no dither logic is built.
//
// Parameters
//   COLOR_W  output bits per channel (legal range 1..8)
//   X_W/Y_W  width of the pixel x / y coordinate
//
// Ports
//   clk_in, rst_in            clock and synchronous active-high reset
//   r_in/g_in/b_in            float32 channel inputs
//   x_in/y_in/visible_in      sideband carried alongside the pixel
//   valid_in / ready_in       input handshake
//   r_out/g_out/b_out         integer channel outputs
//   x_out/y_out/visible_out   sideband aligned with the outputs
//   valid_out / ready_out     output handshake
//   clr_stats                 one-cycle clear of clamp_count (beats an increment)
//   clamp_count               saturating count of clamped pixels sent downstream
module pixel_rgb_formatter #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 11,
    parameter int Y_W     = 10
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [31:0]        r_in,
    input  logic [31:0]        g_in,
    input  logic [31:0]        b_in,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    input  logic               visible_in,
    input  logic               valid_in,
    output logic               ready_in,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic               visible_out,
    output logic               valid_out,
    input  logic               ready_out,
    input  logic               clr_stats,
    output logic [15:0]        clamp_count
);

    // Two extra fraction bits are kept through alignment only when the
    // quarter-step dither has to be added before truncation.
`ifdef PIXEL_FMT_DITHER_EN
    localparam int FRAC_W = 2;
`else
    localparam int FRAC_W = 0;
`endif
    localparam int Q_W = COLOR_W + FRAC_W;

    // For a normal float 1.m * 2^(e-127), floor(v * 2^Q_W) is the 24-bit
    // significand {1,m} shifted right by (127 + 23 - Q_W) - e. For every
    // in-range exponent (1..126) and COLOR_W <= 8 this is a right shift of
    // at least 14, so no left-shift path is needed.
    localparam int SH_BASE = 150 - Q_W;

    // Per-channel outcome decided in the classify stage.
    typedef enum logic [1:0] {
        CL_ZERO  = 2'd0,   // +/-0, denormal, negative, NaN, -inf
        CL_MAX   = 2'd1,   // >= 1.0 or +inf
        CL_RANGE = 2'd2    // normal value in (0,1): needs alignment
    } cls_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           vis;
    } side_t;

    typedef struct packed {
        cls_e        cls;
        logic [7:0]  exp;
        logic [22:0] man;
    } chan1_t;

    typedef struct packed {
        cls_e           cls;
        logic [Q_W-1:0] q;
    } chan2_t;

    typedef struct packed {
        chan1_t [2:0] ch;
        logic         clamp;
        side_t        sb;
    } st1_t;

    typedef struct packed {
        chan2_t [2:0] ch;
        logic         clamp;
        side_t        sb;
    } st2_t;

    typedef struct packed {
        logic [2:0][COLOR_W-1:0] pix;
        logic                    clamp;
        side_t                   sb;
    } st3_t;

    // ------------------------------------------------------------------
    // Channel helpers
    // ------------------------------------------------------------------
    function automatic cls_e classify(input logic [31:0] f);
        logic [7:0] e;
        logic [22:0] m;
        e = f[30:23];
        m = f[22:0];
        // NaN and -inf go to zero, +inf saturates.
        if (e == 8'hFF) return (m == '0 && !f[31]) ? CL_MAX : CL_ZERO;
        if (f[31] || e == 8'h00) return CL_ZERO;
        if (e >= 8'd127) return CL_MAX;
        return CL_RANGE;
    endfunction

    // Clamped: NaN, any nonzero negative value (-0 excluded), or >= 1.0.
    function automatic logic is_clamped(input logic [31:0] f);
        logic nan, neg, big;
        nan = (f[30:23] == 8'hFF) && (f[22:0] != '0);
        neg = f[31] && (f[30:0] != '0);
        big = !f[31] && (f[30:23] >= 8'd127);
        return nan | neg | big;
    endfunction

    // Exact truncation of v * 2^Q_W for an in-range normal value.
    function automatic logic [Q_W-1:0] align(input logic [7:0] e, input logic [22:0] m);
        logic [23:0] full;
        int          sh;
        full = {1'b1, m};
        sh   = SH_BASE - int'(e);
        if (sh < 0 || sh >= 24) return '0;
        return Q_W'(full >> sh);
    endfunction

`ifdef PIXEL_FMT_DITHER_EN
    // floor(v*2^C + d/4) == floor((floor(v*2^(C+2)) + d) / 4) because d is
    // an integer, so adding d to the two-fraction-bit value and dropping the
    // fraction is exact. The sum can reach 2^C, hence the saturation.
    function automatic logic [COLOR_W-1:0] quantise(input chan2_t c, input logic [1:0] d);
        logic [Q_W:0]     sum;
        logic [COLOR_W:0] lvl;
        sum = {1'b0, c.q} + {{(Q_W-1){1'b0}}, d};
        lvl = sum[Q_W:FRAC_W];
        case (c.cls)
            CL_ZERO: return '0;
            CL_MAX:  return '1;
            default: return lvl[COLOR_W] ? {COLOR_W{1'b1}} : lvl[COLOR_W-1:0];
        endcase
    endfunction

    // 2x2 Bayer matrix {{0,2},{3,1}} indexed [y[0]][x[0]].
    function automatic logic [1:0] bayer(input logic y0, input logic x0);
        case ({y0, x0})
            2'b00:   return 2'd0;
            2'b01:   return 2'd2;
            2'b10:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction
`else
    // Without dither v < 1 guarantees the truncated value fits COLOR_W bits.
    function automatic logic [COLOR_W-1:0] quantise(input chan2_t c);
        case (c.cls)
            CL_ZERO: return '0;
            CL_MAX:  return '1;
            default: return c.q;
        endcase
    endfunction
`endif

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic [3:1] vld_q, vld_d;
    logic       s3_free, s2_free, s1_free;
    logic       s2_move, s1_move, accept;

    always_comb begin
        // A stage may take new data when it is empty or its content leaves
        // this cycle; the chain resolves from the output side backwards.
        s3_free  = !vld_q[3] || ready_out;
        s2_move  = vld_q[2] && s3_free;
        s2_free  = !vld_q[2] || s2_move;
        s1_move  = vld_q[1] && s2_free;
        s1_free  = !vld_q[1] || s1_move;
        ready_in = !rst_in && s1_free;
        accept   = valid_in && ready_in;

        vld_d[1] = s1_free ? accept   : vld_q[1];
        vld_d[2] = s2_free ? vld_q[1] : vld_q[2];
        vld_d[3] = s3_free ? vld_q[2] : vld_q[3];
    end

    // ------------------------------------------------------------------
    // Stage datapath
    // ------------------------------------------------------------------
    logic [2:0][31:0] pix_in;
    st1_t s1_q, s1_d;
    st2_t s2_q, s2_d;
    st3_t s3_q, s3_d;

    assign pix_in = {b_in, g_in, r_in};

    // Stage 1: classify each channel and flag the pixel as clamped.
    always_comb begin
        s1_d = s1_q;
        if (accept) begin
            for (int c = 0; c < 3; c++) begin
                s1_d.ch[c].cls = classify(pix_in[c]);
                s1_d.ch[c].exp = pix_in[c][30:23];
                s1_d.ch[c].man = pix_in[c][22:0];
            end
            s1_d.clamp  = is_clamped(r_in) | is_clamped(g_in) | is_clamped(b_in);
            s1_d.sb.x   = x_in;
            s1_d.sb.y   = y_in;
            s1_d.sb.vis = visible_in;
        end
    end

    // Stage 2: align in-range significands to fixed point.
    always_comb begin
        s2_d = s2_q;
        if (s1_move) begin
            for (int c = 0; c < 3; c++) begin
                s2_d.ch[c].cls = s1_q.ch[c].cls;
                s2_d.ch[c].q   = (s1_q.ch[c].cls == CL_RANGE) ?
                                 align(s1_q.ch[c].exp, s1_q.ch[c].man) : '0;
            end
            s2_d.clamp = s1_q.clamp;
            s2_d.sb    = s1_q.sb;
        end
    end

    // Stage 3: quantise into the output register. Loading only on s2_move
    // keeps the outputs frozen while a beat waits for ready_out.
    always_comb begin
        s3_d = s3_q;
        if (s2_move) begin
            for (int c = 0; c < 3; c++) begin
`ifdef PIXEL_FMT_DITHER_EN
                s3_d.pix[c] = quantise(s2_q.ch[c], bayer(s2_q.sb.y[0], s2_q.sb.x[0]));
`else
                s3_d.pix[c] = quantise(s2_q.ch[c]);
`endif
            end
            s3_d.clamp = s2_q.clamp;
            s3_d.sb    = s2_q.sb;
        end
    end

    // ------------------------------------------------------------------
    // Clamp statistics: counted on downstream acceptance, clear wins.
    // ------------------------------------------------------------------
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_stats) begin
            cnt_d = '0;
        end else if (vld_q[3] && ready_out && s3_q.clamp && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            cnt_q <= cnt_d;
        end
    end

    assign r_out       = s3_q.pix[0];
    assign g_out       = s3_q.pix[1];
    assign b_out       = s3_q.pix[2];
    assign x_out       = s3_q.sb.x;
    assign y_out       = s3_q.sb.y;
    assign visible_out = s3_q.sb.vis;
    assign valid_out   = vld_q[3];
    assign clamp_count = cnt_q;

endmodule

// File: tb/tb_pixel_rgb_formatter.sv
// Scoreboard bench for pixel_rgb_formatter. Accepted input beats are turned
// into expected outputs by a real-arithmetic model of the conversion rules
// and queued; a negedge monitor pops and compares on each output handshake,
// and also tracks reset behaviour, stall stability and clamp_count.
module tb_pixel_rgb_formatter;
    localparam int C    = 4;
    localparam int XW   = 11;
    localparam int YW   = 10;
    localparam int MAXV = (1 << C) - 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [31:0]   r_in, g_in, b_in;
    logic [XW-1:0] x_in;
    logic [YW-1:0] y_in;
    logic          visible_in, valid_in, ready_in;
    logic [C-1:0]  r_out, g_out, b_out;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic          visible_out, valid_out, ready_out, clr_stats;
    logic [15:0]   clamp_count;

    pixel_rgb_formatter #(.COLOR_W(C), .X_W(XW), .Y_W(YW)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x_in(x_in), .y_in(y_in), .visible_in(visible_in),
        .valid_in(valid_in), .ready_in(ready_in),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .x_out(x_out), .y_out(y_out), .visible_out(visible_out),
        .valid_out(valid_out), .ready_out(ready_out),
        .clr_stats(clr_stats), .clamp_count(clamp_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int r, g, b, x, y;
        bit vis, clamp, lat;
        int acc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0;
    bit          lat_mode = 1'b1;
    bit          rst_prev = 1'b1;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_out;
    int          exp_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic real fval(input logic [31:0] f);
        real v;
        int  e;
        e = int'(f[30:23]);
        v = real'(f[22:0]) / 8388608.0;
        if (e != 0) v = v + 1.0;
        else e = 1;
        if (e >= 127) repeat (e - 127) v = v * 2.0;
        else repeat (127 - e) v = v / 2.0;
        return f[31] ? -v : v;
    endfunction

    function automatic bit is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 0);
    endfunction

    function automatic int ref_chan(input logic [31:0] f, input int d);
        real v;
        int  o;
        if (is_nan(f)) return 0;
        if (f == 32'h7F80_0000) return MAXV;
        if (f == 32'hFF80_0000) return 0;
        if (f[30:23] == 8'h00) return 0;      // zeros and denormals
        v = fval(f);
        if (v <= 0.0) return 0;
        if (v >= 1.0) return MAXV;
        o = int'($floor(v * real'(1 << C) + real'(d) / 4.0));
        return (o > MAXV) ? MAXV : o;
    endfunction

    function automatic bit ref_clamp(input logic [31:0] f);
        if (is_nan(f)) return 1'b1;
        if (f[31]) return f[30:0] != 0;
        if (f[30:23] == 8'hFF) return 1'b1;
        return fval(f) >= 1.0;
    endfunction

    function automatic int dither(input bit x0, input bit y0);
`ifdef PIXEL_FMT_DITHER_EN
        int bt[2][2] = '{'{0, 2}, '{3, 1}};
        return bt[y0][x0];
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] rand_float();
        logic [22:0] m;
        m = 23'($urandom);
        case ($urandom_range(0, 11))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return {1'($urandom), 8'h00, m | 23'd1};
            3:       return {1'b1, 8'($urandom_range(1, 254)), m};
            4:       return {1'($urandom), 8'hFF, m | 23'd1};
            5:       return 32'h7F80_0000;
            6:       return 32'hFF80_0000;
            7:       return {1'b0, 8'($urandom_range(127, 254)), m};
            default: return {1'b0, 8'($urandom_range(100, 126)), m};
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        exp_t e;
        bit   hs_clamp;
        hs_clamp = 1'b0;
        if (rst_in) begin
            chk("rst_ready_in", ready_in, 0);
            sb.delete();
            exp_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (rst_prev) begin
                chk("post_rst_valid", valid_out, 0);
                chk("post_rst_ready_in", ready_in, 1);
                chk("post_rst_count", clamp_count, 0);
                chk("post_rst_data", {r_out, g_out, b_out, x_out, y_out, visible_out}, 0);
            end
            if (prev_stall)
                chk("stall_stable", {r_out, g_out, b_out, x_out, y_out, visible_out, valid_out}, prev_out);
            chk("clamp_count", clamp_count, exp_cnt);
            if (valid_out && ready_out) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("r", r_out, e.r);
                    chk("g", g_out, e.g);
                    chk("b", b_out, e.b);
                    chk("xy", {x_out, y_out}, {XW'(e.x), YW'(e.y)});
                    chk("vis", visible_out, e.vis);
                    if (e.lat) chk("latency", cyc - e.acc, 3);
                    hs_clamp = e.clamp;
                end
            end
            if (clr_stats) exp_cnt = 0;
            else if (hs_clamp && exp_cnt < 65535) exp_cnt++;
            prev_stall = valid_out && !ready_out;
            prev_out   = {r_out, g_out, b_out, x_out, y_out, visible_out, valid_out};
            if (valid_in && ready_in) begin
                e.r     = ref_chan(r_in, dither(x_in[0], y_in[0]));
                e.g     = ref_chan(g_in, dither(x_in[0], y_in[0]));
                e.b     = ref_chan(b_in, dither(x_in[0], y_in[0]));
                e.x     = int'(x_in);
                e.y     = int'(y_in);
                e.vis   = visible_in;
                e.clamp = ref_clamp(r_in) || ref_clamp(g_in) || ref_clamp(b_in);
                e.lat   = lat_mode;
                e.acc   = cyc;
                sb.push_back(e);
            end
        end
        rst_prev = rst_in;
    end

    // ---------------- driver ----------------
    task automatic send(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                        input int x, input int y, input bit vis);
        int n;
        r_in = r; g_in = g; b_in = b;
        x_in = XW'(x); y_in = YW'(y); visible_in = vis;
        valid_in = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_in);
            if (ready_in) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk_in); #1;
    endtask

    task automatic drain();
        int n;
        valid_in = 1'b0;
        n = 0;
        while ((sb.size() != 0 || valid_out) && n < 300) begin
            @(posedge clk_in); #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #(950_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        rst_in = 1'b1; valid_in = 1'b0; ready_out = 1'b1; clr_stats = 1'b0;
        r_in = '0; g_in = '0; b_in = '0; x_in = '0; y_in = '0; visible_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Basic conversion, in-range only.
        send(32'h3F00_0000, 32'h3F7F_BE77, 32'h0000_0000, 5, 7, 1'b1);
        drain();
        chk("count_unchanged", clamp_count, 0);

        // Clamp cases, back to back.
        send(32'h3F80_0000, 32'h3E80_0000, 32'h3E80_0000, 1, 2, 1'b0);
        send(32'h3E80_0000, 32'hBE80_0000, 32'h3E80_0000, 3, 4, 1'b1);
        send(32'h3E80_0000, 32'h3E80_0000, 32'h7FC0_0000, 6, 8, 1'b0);
        drain();
        chk("count_three", clamp_count, 3);

        // Dither-sensitive value at two Bayer positions.
        send(32'h3F0C_0000, 32'h3F0C_0000, 32'h3F0C_0000, 0, 1, 1'b1);
        send(32'h3F0C_0000, 32'h3F0C_0000, 32'h3F0C_0000, 0, 0, 1'b1);
        drain();

        // Ten beats with a downstream stall.
        lat_mode = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(rand_float(), rand_float(), rand_float(), 100 + i, i, i[0]);
                valid_in = 1'b0;
            end
            begin
                @(posedge clk_in); #1 ready_out = 1'b0;
                repeat (5) @(posedge clk_in);
                @(negedge clk_in);
                chk("stall_ready_in", ready_in, 0);
                chk("stall_depth", sb.size(), 3);
                @(posedge clk_in); #1 ready_out = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        valid_in = 1'b0;
                        @(posedge clk_in); #1;
                    end
                    send(rand_float(), rand_float(), rand_float(),
                         int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'($urandom));
                end
                valid_in = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_in); #1;
                    ready_out = ($urandom_range(0, 3) != 0);
                end
                ready_out = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight; a new beat afterwards.
        lat_mode = 1'b1;
        send(32'h3F80_0000, 32'h3F00_0000, 32'h0, 11, 12, 1'b1);
        send(32'h3F00_0000, 32'h3F80_0000, 32'h0, 13, 14, 1'b1);
        valid_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in); #1 rst_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        send(32'h3E80_0000, 32'h3F00_0000, 32'h3F40_0000, 21, 22, 1'b0);
        drain();

        // Drive the counter into saturation.
        for (int i = 0; i < 65540; i++)
            send(32'h3F80_0000, 32'h0, 32'h0, i & 2047, i & 1023, 1'b1);
        drain();
        chk("count_saturated", clamp_count, 16'hFFFF);

        // Clear coinciding with a clamped beat leaving.
        send(32'hBF00_0000, 32'h0, 32'h0, 9, 9, 1'b1);
        valid_in = 1'b0;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        chk("clr_align_valid", valid_out, 1);
        clr_stats = 1'b1;
        @(posedge clk_in); #1 clr_stats = 1'b0;
        @(negedge clk_in);
        chk("clr_wins", clamp_count, 0);
        @(posedge clk_in); #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pixel_rgb_formatter.md
PIXEL_RGB_FORMATTER -- requirements
Module: pixel_rgb_formatter

Interface
REQ-001 Parameter COLOR_W, default 4: output bits per colour channel, legal range 1..8.
REQ-002 Parameter X_W, default 11: pixel x coordinate width.
REQ-003 Parameter Y_W, default 10: pixel y coordinate width.
REQ-004 Port clk_in, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-005 Port rst_in, input, 1: reset, synchronous and active-high.
REQ-006 Ports r_in / g_in / b_in, input, 32 each: IEEE-754 single-precision channel intensities, nominal range [0,1).
REQ-007 Ports x_in / y_in, input, X_W / Y_W: pixel coordinate sideband.
REQ-008 Port visible_in, input, 1: block-visible sideband.
REQ-009 Port valid_in, input, 1: input beat valid.
REQ-010 Port ready_in, output, 1: the block accepts a beat when valid_in and ready_in are both high.
REQ-011 Ports r_out / g_out / b_out, output, COLOR_W each: integer channel values.
REQ-012 Ports x_out / y_out / visible_out, output, X_W / Y_W / 1: sideband aligned with the RGB outputs.
REQ-013 Port valid_out, output, 1: output beat valid.
REQ-014 Port ready_out, input, 1: downstream accepts a beat when valid_out and ready_out are both high.
REQ-015 Port clr_stats, input, 1: single-cycle clear of clamp_count.
REQ-016 Port clamp_count, output, 16: saturating count of clamped pixels.

Function
REQ-017 The datapath SHALL be a three-stage pipeline (classify, align, quantise); with ready_out held high, the latency from an accepted input beat to valid_out is exactly 3 cycles, and the throughput is 1 beat per cycle.
REQ-018 Each stage SHALL hold when its successor is full and not draining; ready_in = !stage1_full | stage1_advances; no beat is dropped or duplicated, and beats leave in acceptance order.
REQ-019 While valid_out is high and ready_out is low, all outputs SHALL remain stable.
REQ-020 Per channel, with v the float value: +0, -0, denormal, any negative value, or NaN SHALL give 0; v >= 1.0 or +inf SHALL give 2^COLOR_W-1; otherwise the output SHALL be min(floor(v*2^COLOR_W), 2^COLOR_W-1), computed exactly from the exponent and mantissa (no rounding up).
REQ-021 A pixel is clamped when any channel is NaN, is negative and nonzero, or is >= 1.0 (including +inf).
REQ-022 clamp_count SHALL increment by 1 when a clamped pixel's output beat is accepted downstream, and SHALL saturate at 0xFFFF.
REQ-023 If clr_stats and an increment coincide, clamp_count SHALL become 0 (clear wins).
REQ-024 Sideband (x, y, visible) SHALL travel in the same stage registers as its pixel and never skew from it.

Reset
REQ-025 While rst_in is high: all stage-valid flags SHALL clear, valid_out=0, ready_in=0, clamp_count=0, and r_out/g_out/b_out/x_out/y_out/visible_out=0.
REQ-026 In the first cycle after rst_in falls, ready_in SHALL be 1.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight beats; no beat accepted before reset appears after it.

Configuration
REQ-028 Macro PIXEL_FMT_DITHER_EN defined: 2x2 ordered dithering SHALL be applied. The dither value d is bayer[y_in[0]][x_in[0]], with bayer = {{0,2},{3,1}}. The in-range output SHALL be min(floor(v*2^COLOR_W + d/4), 2^COLOR_W-1). The zero and clamp cases of REQ-020 are unchanged, and the latency stays at 3 cycles.
REQ-029 Macro PIXEL_FMT_DITHER_EN undefined: no dither logic SHALL be present, and the output SHALL follow REQ-020 exactly.

Verification
REQ-030 COLOR_W=4, ready_out=1, beat r=0x3F000000 (0.5), g=0x3F7FBE77 (0.999), b=0x00000000, x=5, y=7 -> 3 cycles later valid_out=1, r=8, g=15, b=0, x_out=5, y_out=7, clamp_count unchanged.
REQ-031 Beats r=0x3F800000 (1.0), then g=0xBE800000 (-0.25), then b=0x7FC00000 (NaN), all other channels 0.25 -> outputs (15,4,4), (4,0,4), (4,4,0); clamp_count=3.
REQ-032 Ten back-to-back beats, ready_out low for cycles 2..7 -> ready_in falls once 3 beats are buffered; all ten beats emerge in order with unchanged values; outputs are stable while stalled.
REQ-033 With clamp_count=0xFFFF, a clamped beat -> clamp_count stays 0xFFFF; clr_stats coinciding with a clamped beat -> clamp_count=0.
REQ-034 Two beats in flight, then rst_in pulsed for 1 cycle -> valid_out=0 and no stale beat appears afterwards; a new beat emerges 3 cycles after acceptance.
REQ-035 With PIXEL_FMT_DITHER_EN defined and COLOR_W=4, v=0x3F0C0000 (0.546875, v*16=8.75) at (x=0,y=1), d=3 -> 9; at (x=0,y=0), d=0 -> 8.
